seq_detect_param: RTL and testbench
===================================

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 SHALL provide parameters, one per line: name, default, meaning:
  SYM_W  2  bits per input symbol
  SEQ_LEN  3  symbols in target sequence, legal range 2..8
  PAT_DEF  6'b00_10_11  reset pattern, width SEQ_LEN*SYM_W, oldest symbol in MS slot
  MEALY  1  1 = combinational detect output, 0 = registered (one cycle later)
  OVERLAP  1  1 = matches may share symbols, 0 = history cleared after each match
  CNT_W  8  match counter width
REQ-002 SHALL have ports, one per line: name  direction  width  meaning:
  clk  in  1  single clock, rising edge
  rst  in  1  synchronous, active-high reset
  sym_in  in  SYM_W  input symbol
  sym_valid  in  1  sym_in accepted this edge
  pat_in  in  SEQ_LEN*SYM_W  new pattern
  pat_load  in  1  latch pat_in, flush history
  cnt_clr  in  1  clear match counter
  z  out  1  detection pulse
  fill  out  clog2(SEQ_LEN+1)  valid symbols held in history
  match_cnt  out  CNT_W  saturating detection count
REQ-003 One clock; reset SHALL be synchronous and active-high.

Function
REQ-004 History SHALL be a SEQ_LEN-deep shift register of SYM_W symbols; each accepted symbol shifts in at the newest slot.
REQ-005 fill SHALL increment on each accepted symbol and saturate at SEQ_LEN.
REQ-006 FSM states SHALL be EMPTY (fill=0), FILLING (0<fill<SEQ_LEN) and FULL (fill=SEQ_LEN), with transitions driven only by accepted symbols, pat_load, rst and the no-overlap flush.
REQ-007 A detection SHALL occur on an edge where sym_valid=1, fill>=SEQ_LEN-1, and {newest SEQ_LEN-1 history symbols, sym_in} equals the pattern register.
REQ-008 MEALY=1: z SHALL be high combinationally in the detecting cycle; MEALY=0: z SHALL be high exactly one cycle after the detecting edge.
REQ-009 OVERLAP=0: after a detection, fill SHALL become 0 (state EMPTY) and history contents SHALL be treated as invalid; OVERLAP=1: fill SHALL stay at SEQ_LEN.
REQ-010 Symbols with sym_valid=0 SHALL leave history, fill and state unchanged; z SHALL be 0 in Mealy mode during such cycles.
REQ-011 pat_load=1 SHALL latch pat_in into the pattern register, set fill to 0 and suppress detection that cycle; a simultaneous sym_valid symbol SHALL be discarded.
REQ-012 match_cnt SHALL increment by 1 per detection and saturate at 2^CNT_W-1, with no wrap.
REQ-013 cnt_clr SHALL set match_cnt to 0; cnt_clr together with a detection SHALL yield 0 (clear wins).
REQ-014 A detection SHALL update match_cnt on the detecting edge in both modes.

Reset
REQ-015 rst SHALL set pattern=PAT_DEF, history=0, fill=0, state EMPTY, match_cnt=0, and registered z=0.
REQ-016 rst SHALL take priority over pat_load, cnt_clr and sym_valid; in Mealy mode z SHALL be 0 while rst=1.
REQ-017 Reset mid-sequence SHALL discard the partial match; no detection SHALL complete on the first SEQ_LEN-1 symbols after rst.

Structure
REQ-018 The shared package SHALL hold the FSM state enum (EMPTY, FILLING, FULL), the default SYM_W/SEQ_LEN/PAT_DEF constants and a fill-width function.
REQ-019 The history shift register SHALL be one sub-module, sym_history (parameters SYM_W, SEQ_LEN; inputs shift, flush; output of the whole history vector).
REQ-020 FSM, comparator and counter SHALL reside in seq_detect_param.

Verification
REQ-021 Defaults, rst, then symbols 00,10,11 valid on consecutive edges -> z high during the third cycle, match_cnt=1.
REQ-022 MEALY=0, same stimulus -> z low during the third cycle, high exactly one cycle later, match_cnt=1.
REQ-023 Pattern 2'b01,01 (SEQ_LEN=2) loaded, stream 01,01,01: OVERLAP=1 -> 2 detections; OVERLAP=0 -> 1 detection, fill=1 at end.
REQ-024 Stream 00,10, then rst, then 11 -> no detection, fill=1, match_cnt=0.
REQ-025 CNT_W=2: 5 detections -> match_cnt saturates at 3; cnt_clr asserted on a detecting edge -> match_cnt=0.
REQ-026 Stream 00,10 with sym_valid gaps of 3 idle cycles, then pat_load together with sym_valid 11 -> no detection, fill=0, new pattern active.

Source files
------------

// File: rtl/seq_detect_param_pkg.sv
// rtl/seq_detect_param_pkg.sv - shared state enum, default constants and fill-width helper
package seq_detect_param_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } state_t;

  localparam int DEF_SYM_W   = 2;
  localparam int DEF_SEQ_LEN = 3;
  localparam logic [DEF_SEQ_LEN*DEF_SYM_W-1:0] DEF_PAT = 6'b00_10_11;

  function automatic int fill_w(input int seq_len);
    return $clog2(seq_len + 1);
  endfunction

endpackage

// File: rtl/sym_history.sv
// rtl/sym_history.sv - SEQ_LEN-deep symbol shift register, newest symbol in the LS slot
module sym_history
  import seq_detect_param_pkg::*;
#(
  parameter int SYM_W   = DEF_SYM_W,
  parameter int SEQ_LEN = DEF_SEQ_LEN
) (
  input  logic                     clk,
  input  logic                     shift,
  input  logic                     flush,
  input  logic [SYM_W-1:0]         sym,
  output logic [SEQ_LEN*SYM_W-1:0] hist
);

  // flush wins over shift so a discarded symbol never lands in the history
  always_ff @(posedge clk) begin
    if (flush) begin
      hist <= '0;
    end else if (shift) begin
      hist <= {hist[(SEQ_LEN-1)*SYM_W-1:0], sym};
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - parameterised symbol-sequence detector with saturating match counter
module seq_detect_param
  import seq_detect_param_pkg::*;
#(
  parameter int                         SYM_W   = DEF_SYM_W,
  parameter int                         SEQ_LEN = DEF_SEQ_LEN,
  parameter logic [SEQ_LEN*SYM_W-1:0]   PAT_DEF = DEF_PAT,
  parameter bit                         MEALY   = 1'b1,
  parameter bit                         OVERLAP = 1'b1,
  parameter int                         CNT_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [SYM_W-1:0]             sym_in,
  input  logic                         sym_valid,
  input  logic [SEQ_LEN*SYM_W-1:0]     pat_in,
  input  logic                         pat_load,
  input  logic                         cnt_clr,
  output logic                         z,
  output logic [fill_w(SEQ_LEN)-1:0]   fill,
  output logic [CNT_W-1:0]             match_cnt
);

  localparam int PW     = SEQ_LEN * SYM_W;
  localparam int FILL_W = fill_w(SEQ_LEN);

  state_t          state;
  logic [PW-1:0]   pat;
  logic [PW-1:0]   hist;
  logic            det;
  logic            z_q;
  logic            flush;
  logic            unused_oldest;

  sym_history #(
    .SYM_W   (SYM_W),
    .SEQ_LEN (SEQ_LEN)
  ) u_hist (
    .clk   (clk),
    .shift (sym_valid),
    .flush (flush),
    .sym   (sym_in),
    .hist  (hist)
  );

  // the oldest slot drops out as the incoming symbol completes the window
  assign unused_oldest = ^hist[PW-1 -: SYM_W];

  assign det = sym_valid && !rst && !pat_load
            && (fill >= FILL_W'(SEQ_LEN - 1))
            && ({hist[(SEQ_LEN-1)*SYM_W-1:0], sym_in} == pat);

  assign flush = rst || pat_load || (det && !OVERLAP);
  assign z     = MEALY ? det : z_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      fill  <= '0;
      pat   <= PAT_DEF;
      z_q   <= 1'b0;
    end else begin
      z_q <= det;
      if (pat_load) begin
        pat   <= pat_in;
        state <= EMPTY;
        fill  <= '0;
      end else if (sym_valid) begin
        if (det && !OVERLAP) begin
          state <= EMPTY;
          fill  <= '0;
        end else begin
          case (state)
            EMPTY, FILLING: begin
              fill  <= fill + FILL_W'(1);
              state <= (fill == FILL_W'(SEQ_LEN - 1)) ? FULL : FILLING;
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      match_cnt <= '0;
    end else if (det && (match_cnt != '1)) begin
      match_cnt <= match_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_seq_detect_param.sv
// tb/tb_seq_detect_param.sv - scoreboarded random/directed bench over four detector configurations
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] sym_in = '0;
  logic       sym_valid = 1'b0;
  logic [5:0] pat3 = '0;
  logic [3:0] pat2 = '0;
  logic       pat_load = 1'b0;
  logic       cnt_clr = 1'b0;

  logic       z_a, z_b, z_c, z_d;
  logic [1:0] fill_a, fill_b, fill_c, fill_d;
  logic [7:0] cnt_a, cnt_c;
  logic [1:0] cnt_b, cnt_d;

  always #5 clk = ~clk;

  seq_detect_param u_a (
    .clk(clk), .rst(rst), .sym_in(sym_in), .sym_valid(sym_valid), .pat_in(pat3),
    .pat_load(pat_load), .cnt_clr(cnt_clr), .z(z_a), .fill(fill_a), .match_cnt(cnt_a));

  seq_detect_param #(.MEALY(1'b0), .OVERLAP(1'b0), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .sym_in(sym_in), .sym_valid(sym_valid), .pat_in(pat3),
    .pat_load(pat_load), .cnt_clr(cnt_clr), .z(z_b), .fill(fill_b), .match_cnt(cnt_b));

  seq_detect_param #(.SEQ_LEN(2), .PAT_DEF(4'b01_01), .MEALY(1'b1), .OVERLAP(1'b0)) u_c (
    .clk(clk), .rst(rst), .sym_in(sym_in), .sym_valid(sym_valid), .pat_in(pat2),
    .pat_load(pat_load), .cnt_clr(cnt_clr), .z(z_c), .fill(fill_c), .match_cnt(cnt_c));

  seq_detect_param #(.SEQ_LEN(2), .PAT_DEF(4'b01_01), .MEALY(1'b0), .OVERLAP(1'b1), .CNT_W(2)) u_d (
    .clk(clk), .rst(rst), .sym_in(sym_in), .sym_valid(sym_valid), .pat_in(pat2),
    .pat_load(pat_load), .cnt_clr(cnt_clr), .z(z_d), .fill(fill_d), .match_cnt(cnt_d));

  typedef struct packed {
    logic [3:0]      z;
    logic [3:0][7:0] fill;
    logic [3:0][7:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cycle = 0;

  // reference model: a list of recent accepted symbols (index 0 newest) and a symbol-list pattern
  int m_len[4]   = '{3, 3, 2, 2};
  int m_max[4]   = '{255, 3, 255, 3};
  bit m_mealy[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  bit m_ovl[4]   = '{1'b1, 1'b0, 1'b0, 1'b1};
  int m_def[4][8];
  int m_pat[4][8];
  int m_recent[4][8];
  int m_fill[4];
  int m_cnt[4];
  bit m_zreg[4];

  function automatic bit model_det(int i, bit r, bit sv, int sym, bit pl);
    if (r || pl || !sv || (m_fill[i] < m_len[i] - 1)) return 1'b0;
    if (sym != m_pat[i][m_len[i]-1]) return 1'b0;
    for (int j = 0; j < m_len[i] - 1; j++)
      if (m_recent[i][j] != m_pat[i][m_len[i]-2-j]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      for (int p = 0; p < 8; p++) m_pat[i][p] = m_def[i][p];
      m_fill[i] = 0;
      m_cnt[i]  = 0;
      m_zreg[i] = 1'b0;
    end
  endtask

  task automatic step(input bit r, input bit sv, input int sym, input bit pl,
                      input int p3, input int p2, input bit cc);
    exp_t e;
    bit   det;
    int   pv;
    @(posedge clk);
    #1;
    rst = r; sym_valid = sv; sym_in = sym[1:0]; pat_load = pl;
    pat3 = p3[5:0]; pat2 = p2[3:0]; cnt_clr = cc;
    e = '0;
    for (int i = 0; i < 4; i++) begin
      det       = model_det(i, r, sv, sym, pl);
      e.z[i]    = m_mealy[i] ? det : m_zreg[i];
      e.fill[i] = 8'(m_fill[i]);
      e.cnt[i]  = 8'(m_cnt[i]);
      m_zreg[i] = det;
      if (r) begin
        for (int p = 0; p < 8; p++) m_pat[i][p] = m_def[i][p];
        m_fill[i] = 0;
      end else if (pl) begin
        pv = (m_len[i] == 3) ? p3 : p2;
        for (int p = 0; p < m_len[i]; p++) m_pat[i][p] = (pv >> ((m_len[i] - 1 - p) * 2)) & 3;
        m_fill[i] = 0;
      end else if (sv) begin
        if (det && !m_ovl[i]) begin
          m_fill[i] = 0;
        end else begin
          for (int j = 7; j > 0; j--) m_recent[i][j] = m_recent[i][j-1];
          m_recent[i][0] = sym;
          if (m_fill[i] < m_len[i]) m_fill[i]++;
        end
      end
      if (r || cc) m_cnt[i] = 0;
      else if (det && m_cnt[i] < m_max[i]) m_cnt[i]++;
    end
    exp_q.push_back(e);
  endtask

  task automatic sv(input int sym);
    step(0, 1, sym, 0, 0, 0, 0);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic reset1();
    step(1, 0, 0, 0, 0, 0, 0);
  endtask

  // monitor: every cycle the DUTs present outputs, pop one expected record and compare
  initial begin
    exp_t e, a;
    forever begin
      @(negedge clk);
      cycle++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a.z    = {z_d, z_c, z_b, z_a};
        a.fill = {{6'b0, fill_d}, {6'b0, fill_c}, {6'b0, fill_b}, {6'b0, fill_a}};
        a.cnt  = {{6'b0, cnt_d}, cnt_c, {6'b0, cnt_b}, cnt_a};
        for (int i = 0; i < 4; i++) begin
          tests++;
          if (a.z[i] !== e.z[i]) begin
            fails++;
            $display("FAIL z[%0d] cycle %0d: got %0d expected %0d", i, cycle, a.z[i], e.z[i]);
          end
          tests++;
          if (a.fill[i] !== e.fill[i]) begin
            fails++;
            $display("FAIL fill[%0d] cycle %0d: got %0d expected %0d", i, cycle, a.fill[i], e.fill[i]);
          end
          tests++;
          if (a.cnt[i] !== e.cnt[i]) begin
            fails++;
            $display("FAIL match_cnt[%0d] cycle %0d: got %0d expected %0d", i, cycle, a.cnt[i], e.cnt[i]);
          end
        end
      end
    end
  end

  initial begin
    int wait_cyc;
    m_def[0] = '{0, 2, 3, 0, 0, 0, 0, 0};
    m_def[1] = '{0, 2, 3, 0, 0, 0, 0, 0};
    m_def[2] = '{1, 1, 0, 0, 0, 0, 0, 0};
    m_def[3] = '{1, 1, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 8; j++) m_recent[i][j] = 0;
    model_reset();
    repeat (2) @(posedge clk);

    reset1(); reset1();
    sv(0); sv(2); sv(3); idle(); idle();

    reset1();
    sv(1); sv(1); sv(1); idle();

    reset1();
    sv(0); sv(2); reset1(); sv(3); idle();

    reset1();
    repeat (5) begin sv(0); sv(2); sv(3); end
    sv(0); sv(2); step(0, 1, 3, 0, 0, 0, 1); idle();
    repeat (6) sv(1);
    step(0, 1, 1, 0, 0, 0, 1); idle();

    reset1();
    sv(0); repeat (3) idle();
    sv(2); repeat (3) idle();
    step(0, 1, 3, 1, 6'b11_01_00, 4'b11_10, 0);
    sv(3); sv(1); sv(0); sv(2); sv(3); sv(2); idle(); idle();

    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(99) < 2, $urandom_range(99) < 75, $urandom_range(3),
           $urandom_range(99) < 2, $urandom_range(63), $urandom_range(15),
           $urandom_range(99) < 3);
    end
    idle(); idle();

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    if (exp_q.size() > 0) begin
      fails++;
      $display("FAIL drain: got %0d pending records expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
